uart_tx_buffered: RTL and testbench
===================================

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (100 MHz / 115200 baud).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning byte-FIFO entries; power of two, 2..256.
REQ-003 SHALL have port clk  input  1  single system clock, all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port wr_en  input  1  request to enqueue wr_data, sampled on the clk edge.
REQ-006 SHALL have port wr_data  input  8  byte to transmit.
REQ-007 SHALL have port full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-008 SHALL have port count  output  $clog2(FIFO_DEPTH)+1  bytes currently queued, excluding the byte on the line.
REQ-009 SHALL have port overflow  output  1  sticky flag: a write was dropped.
REQ-010 SHALL have port tx  output  1  serial line, 8N1, LSB first, idle high.
REQ-011 SHALL have port tx_busy  output  1  serializer not in IDLE.

Function
REQ-012 SHALL implement a circular FIFO with FIFO_DEPTH entries, independent read and write pointers, and a registered count.
REQ-013 SHALL enqueue wr_data when wr_en=1 and full=0; count increments on the next edge unless a pop occurs in the same cycle.
REQ-014 SHALL drop the write when wr_en=1 and full=1, even if a pop occurs that cycle; overflow is set to 1 and held until reset.
REQ-015 SHALL let the FIFO pointers wrap modulo FIFO_DEPTH with no loss or duplication of data.
REQ-016 SHALL drive full = (count==FIFO_DEPTH), registered together with count.
REQ-017 SHALL implement serializer FSM states IDLE, START, DATA, STOP, plus a bit-cycle counter 0..CLKS_PER_BIT-1 and a bit index 0..7.
REQ-018 SHALL, in IDLE with count>0, pop the head byte into the shift register and enter START on the same edge.
REQ-019 SHALL NOT pop in a cycle where count==0, even if wr_en=1; a byte written into an empty FIFO is popped on the following cycle.
REQ-020 SHALL hold tx=0 in START for exactly CLKS_PER_BIT cycles, then enter DATA with bit index 0.
REQ-021 SHALL hold tx = bit[index] in DATA for CLKS_PER_BIT cycles per bit, index 0 to 7, then enter STOP.
REQ-022 SHALL hold tx=1 in STOP for CLKS_PER_BIT cycles.
REQ-023 SHALL, on the last STOP cycle with count>0, pop the next byte and go straight to START, giving no idle gap between frames.
REQ-024 SHALL, on the last STOP cycle with count==0, return to IDLE.
REQ-025 SHALL make tx a registered output with no glitches; the first tx falling edge occurs 2 clk edges after the edge that samples wr_en into an idle, empty block.
REQ-026 SHALL make each frame exactly 10*CLKS_PER_BIT cycles long.
REQ-027 SHALL drive tx_busy=1 in START, DATA and STOP, and 0 in IDLE.
REQ-028 SHALL update count once when a write and a pop occur in the same cycle, with a net change of 0.

Reset
REQ-029 SHALL, while rst=1, immediately force tx=1, tx_busy=0, count=0, full=0, overflow=0, FSM=IDLE, pointers=0, and all counters=0.
REQ-030 SHALL, on rst asserted mid-frame, abort the frame, return tx to 1 asynchronously, and discard FIFO contents; no partial frame resumes after release.
REQ-031 SHALL NOT accept a write on the first edge after rst deasserts unless rst is low at that edge.

Verification
REQ-032 SHALL cover: CLKS_PER_BIT=4, write 0xA5 once -> tx sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop), each bit 4 cycles; tx_busy high for 40 cycles.
REQ-033 SHALL cover: write 0x00, 0xFF, 0x55 on consecutive cycles -> three back-to-back frames, 120 cycles total at CLKS_PER_BIT=4, no idle gap, bytes in order.
REQ-034 SHALL cover: FIFO_DEPTH=4, 6 writes in 6 cycles while idle -> 1 byte popped to the line; count peaks at 4, full=1; the 6th write is dropped and overflow=1; 5 frames are transmitted.
REQ-035 SHALL cover: 40 bytes in total (wrap-around) streamed with writes gated on !full -> received byte stream equals the written stream and overflow stays 0.
REQ-036 SHALL cover: rst pulsed during DATA bit 3 -> tx=1 within the same cycle, count=0, tx_busy=0; a subsequent write of 0x3C transmits correctly.
REQ-037 SHALL cover: write into an empty FIFO on the last STOP cycle -> FSM enters IDLE, then pops the byte next cycle; one idle clk cycle appears between frames.

Source files
------------

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_buffered
// Brief    : Byte FIFO feeding an 8N1 UART serializer (LSB first, idle high).
//            Back-to-back frames when the FIFO is non-empty at end of STOP.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          tx,
  output logic                          tx_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CW-1:0] C_BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_CYC_ONE  = CW'(1);
  localparam logic [AW:0]   C_DEPTH    = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   C_CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   C_CNT_ZERO = '0;
  localparam logic [AW-1:0] C_PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // FIFO state
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          full_q;
  logic          overflow_q;

  // Serializer state
  state_t        state_q;
  logic [CW-1:0] cyc_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          busy_q;

  logic          push;
  logic          pop;
  logic          bit_end;

  // A full FIFO rejects writes even when a pop frees a slot in the same cycle.
  assign push    = wr_en & ~full_q;
  assign bit_end = (cyc_q == C_BIT_LAST);
  // Pop only from registered count, so a byte written into an empty FIFO
  // is picked up one cycle later.
  assign pop     = (count_q != C_CNT_ZERO) &
                   ((state_q == S_IDLE) | ((state_q == S_STOP) & bit_end));

  // Next occupancy: simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + C_CNT_ONE;
      2'b01:   count_d = count_q - C_CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Storage array carries no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= wr_data;
    end
  end

  // Pointers, occupancy, full and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + C_PTR_ONE;
      end
      if (pop) begin
        rptr_q <= rptr_q + C_PTR_ONE;
      end
      count_q <= count_d;
      full_q  <= (count_d == C_DEPTH);
      if (wr_en & full_q) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Serializer FSM; tx is re-registered from the current state so the line
  // trails the FSM by one cycle with uniform bit lengths.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_START: tx_q <= 1'b0;
        S_DATA:  tx_q <= shift_q[idx_q];
        default: tx_q <= 1'b1;
      endcase

      case (state_q)
        S_IDLE: begin
          if (pop) begin
            shift_q <= mem_q[rptr_q];
            cyc_q   <= '0;
            state_q <= S_START;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            cyc_q   <= '0;
            idx_q   <= '0;
            state_q <= S_DATA;
          end else begin
            cyc_q <= cyc_q + C_CYC_ONE;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cyc_q <= '0;
            if (idx_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cyc_q <= cyc_q + C_CYC_ONE;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            cyc_q <= '0;
            if (pop) begin
              shift_q <= mem_q[rptr_q];
              state_q <= S_START;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cyc_q <= cyc_q + C_CYC_ONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign full     = full_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign tx       = tx_q;
  assign tx_busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_buffered
// Brief    : Directed self-checking bench for uart_tx_buffered
//            (CLKS_PER_BIT=4, FIFO_DEPTH=4) with a line-decoding receiver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buffered;

  localparam int TB_CPB   = 4;
  localparam int TB_DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic [2:0] count;
  logic       overflow;
  logic       tx;
  logic       tx_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] rx_byte [$];
  int         rx_cyc  [$];
  logic       rx_ok   [$];

  uart_tx_buffered #(
    .CLKS_PER_BIT (TB_CPB),
    .FIFO_DEPTH   (TB_DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .tx       (tx),
    .tx_busy  (tx_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called at a negedge; the byte is sampled on the following posedge.
  task automatic wr_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(posedge clk);
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int c;
    c = 0;
    while (rx_byte.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check_eq("rx_frames", rx_byte.size(), n);
  endtask

  task automatic clear_rx();
    rx_byte.delete();
    rx_cyc.delete();
    rx_ok.delete();
  endtask

  // Line receiver: samples each bit mid-way, records byte, start cycle, framing.
  initial begin : rx_model
    logic [7:0] b;
    logic       ok;
    int         st;
    b = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx === 1'b0) begin
        st = cyc;
        ok = 1'b1;
        repeat (TB_CPB / 2) @(negedge clk);
        if (tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (TB_CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (TB_CPB) @(negedge clk);
        if (tx !== 1'b1) ok = 1'b0;
        repeat (TB_CPB / 2 - 1) @(negedge clk);
        rx_byte.push_back(b);
        rx_cyc.push_back(st);
        rx_ok.push_back(ok);
      end
    end
  end

  initial begin : stim
    logic [9:0] fr;
    logic [7:0] exp_bytes [$];
    int         busy_cnt;
    int         peak;
    int         idx;

    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_tx", tx, 1);
    check_eq("rst_busy", tx_busy, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_full", full, 0);
    check_eq("rst_ovf", overflow, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single frame 0xA5: latency, bit sequence and busy width
    clear_rx();
    fr = {1'b1, 8'hA5, 1'b0};
    wr_byte(8'hA5);
    check_eq("a5_cnt_e0", count, 1);
    check_eq("a5_busy_e0", tx_busy, 0);
    check_eq("a5_tx_e0", tx, 1);
    busy_cnt = 0;
    @(negedge clk);
    check_eq("a5_busy_e1", tx_busy, 1);
    check_eq("a5_cnt_e1", count, 0);
    check_eq("a5_tx_e1", tx, 1);
    if (tx_busy === 1'b1) busy_cnt++;
    for (int k = 0; k < 10 * TB_CPB; k++) begin
      @(negedge clk);
      check_eq("a5_tx_bit", tx, fr[k / TB_CPB]);
      if (tx_busy === 1'b1) busy_cnt++;
    end
    check_eq("a5_busy_len", busy_cnt, 10 * TB_CPB);
    check_eq("a5_busy_end", tx_busy, 0);
    wait_rx(1, 20);
    if (rx_byte.size() >= 1) check_eq("a5_rx", rx_byte[0], 8'hA5);
    repeat (4) @(negedge clk);

    // Three consecutive writes: back-to-back frames in order
    clear_rx();
    wr_byte(8'h00);
    wr_byte(8'hFF);
    wr_byte(8'h55);
    wait_rx(3, 200);
    if (rx_byte.size() >= 3) begin
      check_eq("b2b_rx0", rx_byte[0], 8'h00);
      check_eq("b2b_rx1", rx_byte[1], 8'hFF);
      check_eq("b2b_rx2", rx_byte[2], 8'h55);
      check_eq("b2b_gap01", rx_cyc[1] - rx_cyc[0], 10 * TB_CPB);
      check_eq("b2b_gap12", rx_cyc[2] - rx_cyc[1], 10 * TB_CPB);
      check_eq("b2b_total", rx_cyc[2] - rx_cyc[0] + 10 * TB_CPB, 120);
      check_eq("b2b_frame", {rx_ok[0], rx_ok[1], rx_ok[2]}, 3'b111);
    end
    repeat (4) @(negedge clk);

    // Six writes into a depth-4 FIFO: fill, full, overflow, five frames
    clear_rx();
    peak = 0;
    for (int i = 0; i < 6; i++) begin
      wr_byte(8'(8'h11 * (i + 1)));
      if (int'(count) > peak) peak = int'(count);
      if (i == 4) begin
        check_eq("ovf_full", full, 1);
        check_eq("ovf_ovf_before", overflow, 0);
      end
      if (i == 5) begin
        check_eq("ovf_flag", overflow, 1);
        check_eq("ovf_count", count, 4);
      end
    end
    check_eq("ovf_peak", peak, 4);
    wait_rx(5, 400);
    repeat (60) @(negedge clk);
    check_eq("ovf_frames", rx_byte.size(), 5);
    for (int i = 0; i < 5 && i < rx_byte.size(); i++) begin
      check_eq("ovf_rx", rx_byte[i], 8'(8'h11 * (i + 1)));
    end
    check_eq("ovf_sticky", overflow, 1);
    rst = 1'b1;
    #1;
    check_eq("ovf_rst_clear", overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Stream 40 bytes with writes gated on !full (pointer wrap)
    clear_rx();
    exp_bytes.delete();
    idx = 0;
    for (int c = 0; c < 3000 && rx_byte.size() < 40; c++) begin
      if (idx < 40 && full === 1'b0) begin
        wr_en   = 1'b1;
        wr_data = 8'((idx * 37 + 5) ^ (idx << 3));
        exp_bytes.push_back(wr_data);
        idx++;
      end else begin
        wr_en = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    wr_en = 1'b0;
    check_eq("strm_frames", rx_byte.size(), 40);
    for (int i = 0; i < 40 && i < rx_byte.size(); i++) begin
      check_eq("strm_rx", rx_byte[i], exp_bytes[i]);
    end
    check_eq("strm_ovf", overflow, 0);
    repeat (4) @(negedge clk);
    check_eq("strm_count", count, 0);

    // Reset during DATA bit 3 with a byte still queued
    wr_byte(8'h00);
    wr_byte(8'h00);
    repeat (17) @(negedge clk);
    check_eq("mid_busy_pre", tx_busy, 1);
    check_eq("mid_tx_pre", tx, 0);
    check_eq("mid_cnt_pre", count, 1);
    rst = 1'b1;
    #1;
    check_eq("mid_tx_rst", tx, 1);
    check_eq("mid_busy_rst", tx_busy, 0);
    check_eq("mid_cnt_rst", count, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check_eq("mid_tx_idle", tx, 1);
    check_eq("mid_busy_idle", tx_busy, 0);
    clear_rx();
    wr_byte(8'h3C);
    wait_rx(1, 100);
    if (rx_byte.size() >= 1) begin
      check_eq("mid_rx_3c", rx_byte[0], 8'h3C);
      check_eq("mid_frame", rx_ok[0], 1);
    end
    repeat (4) @(negedge clk);

    // Write on the last STOP cycle of an otherwise empty FIFO: one idle cycle
    clear_rx();
    wr_byte(8'h81);
    repeat (40) @(negedge clk);
    check_eq("gap_busy_stop", tx_busy, 1);
    wr_byte(8'h7E);
    check_eq("gap_busy_idle", tx_busy, 0);
    check_eq("gap_cnt_idle", count, 1);
    @(negedge clk);
    check_eq("gap_busy_restart", tx_busy, 1);
    check_eq("gap_cnt_pop", count, 0);
    wait_rx(2, 200);
    if (rx_byte.size() >= 2) begin
      check_eq("gap_rx0", rx_byte[0], 8'h81);
      check_eq("gap_rx1", rx_byte[1], 8'h7E);
      check_eq("gap_spacing", rx_cyc[1] - rx_cyc[0], 10 * TB_CPB + 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
